// File: rtl/perceptron_weight_bank_if.sv
// perceptron_weight_bank_if
// Prediction/resolution bundle between the index-hash stage, the branch
// resolution stage and the perceptron weight bank.
//   master : the pipeline side (issues predictions and resolutions)
//   slave  : the weight bank
interface perceptron_weight_bank_if #(
    parameter int NUM_WEIGHTS = 16,
    parameter int WEIGHT_W    = 3,
    parameter int INDEX_W     = 10,
    parameter int PIPE_DEPTH  = 4
) ();
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

    // prediction request / response
    logic                            pred_en;
    logic [NUM_WEIGHTS*INDEX_W-1:0]  pred_index;
    logic                            pred_ready;
    logic                            pred_valid;
    logic [NUM_WEIGHTS*WEIGHT_W-1:0] pred_weights;

    // resolution / training
    logic                            res_en;
    logic                            res_train;
    logic [NUM_WEIGHTS-1:0]          res_dir;
    logic                            res_error;

    // status
    logic                            init_busy;
    logic [CNT_W-1:0]                inflight_cnt;

    modport master (
        output pred_en, pred_index, res_en, res_train, res_dir,
        input  pred_ready, pred_valid, pred_weights, res_error,
               init_busy, inflight_cnt
    );

    modport slave (
        input  pred_en, pred_index, res_en, res_train, res_dir,
        output pred_ready, pred_valid, pred_weights, res_error,
               init_busy, inflight_cnt
    );
endinterface

// File: rtl/perceptron_weight_bank.sv
// perceptron_weight_bank
// NUM_WEIGHTS independent weight banks (2**INDEX_W x WEIGHT_W each) with a
// one-cycle prediction read, an internal in-flight FIFO of prediction
// snapshots {index, weights}, saturating +/-1 training from the oldest
// snapshot, and a zeroing sweep after reset.
// Optional build macro: PERCEPTRON_WEIGHT_BYPASS_EN
//   defined   : a read colliding with a training write to the same bank and
//               index returns (and snapshots) the newly written value.
//   undefined : the colliding read returns the pre-write value.
module perceptron_weight_bank #(
    parameter int NUM_WEIGHTS = 16,
    parameter int WEIGHT_W    = 3,
    parameter int INDEX_W     = 10,
    parameter int PIPE_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    perceptron_weight_bank_if.slave bus
);
    localparam int DEPTH     = 2 ** INDEX_W;
    localparam int CNT_W     = $clog2(PIPE_DEPTH + 1);
    localparam int PTR_W     = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int IDX_ALL_W = NUM_WEIGHTS * INDEX_W;
    localparam int WGT_ALL_W = NUM_WEIGHTS * WEIGHT_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIPE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PIPE_DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [0:0]         state_q,      state_d;
    logic [INDEX_W-1:0] init_addr_q,  init_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]   wpend_ptr_q,  wpend_ptr_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               pred_valid_q, pred_valid_d;
    logic               res_error_q,  res_error_d;

    // Snapshot FIFO storage (flushed by pointer reset, contents not reset)
    logic [IDX_ALL_W-1:0] fifo_idx [PIPE_DEPTH];
    logic [WGT_ALL_W-1:0] fifo_w   [PIPE_DEPTH];

    logic                 in_init;
    logic                 in_run;
    logic                 pred_ready;
    logic                 accept;
    logic                 pop;
    logic                 train_we;
    logic                 pend_is_oldest;
    logic [IDX_ALL_W-1:0] snap_idx;
    logic [WGT_ALL_W-1:0] snap_w;
    logic [WGT_ALL_W-1:0] rd_w_all;

    assign in_init = (state_q == ST_INIT);
    assign in_run  = (state_q == ST_RUN);

    // Ready depends only on registered state, never on res_en.
    assign pred_ready = in_run && (cnt_q < CNT_FULL);
    assign accept     = bus.pred_en && pred_ready;
    assign pop        = in_run && bus.res_en && (cnt_q != '0);
    assign train_we   = pop && bus.res_train;

    // The weights of the newest entry only land one cycle after it was
    // pushed; if that entry is already the oldest, take them straight from
    // the read data instead of the not-yet-written FIFO slot.
    assign pend_is_oldest = pred_valid_q && (wpend_ptr_q == rd_ptr_q);

    // Select the oldest snapshot for training
    always_comb begin
        snap_idx = fifo_idx[rd_ptr_q];
        snap_w   = pend_is_oldest ? rd_w_all : fifo_w[rd_ptr_q];
    end

    // Next-state logic for the init sweep FSM
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (in_init) begin
            init_addr_d = init_addr_q + INDEX_W'(1);
            if (init_addr_q == {INDEX_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    // Next-state logic for FIFO pointers, occupancy and response flags
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wpend_ptr_d  = wpend_ptr_q;
        cnt_d        = cnt_q;
        pred_valid_d = accept;
        res_error_d  = in_run && bus.res_en && (cnt_q == '0);

        if (accept) begin
            wr_ptr_d    = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            wpend_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_addr_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wpend_ptr_q  <= '0;
            cnt_q        <= '0;
            pred_valid_q <= 1'b0;
            res_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_addr_q  <= init_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wpend_ptr_q  <= wpend_ptr_d;
            cnt_q        <= cnt_d;
            pred_valid_q <= pred_valid_d;
            res_error_q  <= res_error_d;
        end
    end

    // FIFO payload: index on acceptance, weights one cycle later
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            fifo_idx[wr_ptr_q] <= bus.pred_index;
        end
        if (!rst && pred_valid_q) begin
            fifo_w[wpend_ptr_q] <= rd_w_all;
        end
    end

    // ------------------------------------------------------------------
    // Weight banks
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WEIGHTS; gi++) begin : g_bank
            logic [WEIGHT_W-1:0] mem [DEPTH];
            logic [WEIGHT_W-1:0] ram_rd_q;
            logic [WEIGHT_W-1:0] rd_w;
            logic [INDEX_W-1:0]  rd_addr;
            logic [INDEX_W-1:0]  tr_addr;
            logic [INDEX_W-1:0]  wr_addr;
            logic [WEIGHT_W-1:0] snap_wk;
            logic [WEIGHT_W-1:0] trained;
            logic [WEIGHT_W-1:0] wr_data;
            logic [WEIGHT_W:0]   sum_ext;
            logic                we;

            assign rd_addr = bus.pred_index[gi*INDEX_W +: INDEX_W];
            assign tr_addr = snap_idx[gi*INDEX_W +: INDEX_W];
            assign snap_wk = snap_w[gi*WEIGHT_W +: WEIGHT_W];

            // Saturating +/-1 step on the snapshot weight; the guard bit
            // exposes overflow, which then clamps to the signed min/max.
            always_comb begin
                sum_ext = {snap_wk[WEIGHT_W-1], snap_wk}
                        + (bus.res_dir[gi] ? {{WEIGHT_W{1'b0}}, 1'b1}
                                           : {(WEIGHT_W+1){1'b1}});
                if (sum_ext[WEIGHT_W] != sum_ext[WEIGHT_W-1]) begin
                    trained = sum_ext[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}}
                                                : {1'b0, {(WEIGHT_W-1){1'b1}}};
                end else begin
                    trained = sum_ext[WEIGHT_W-1:0];
                end
            end

            // Single write port: zeroing sweep during init, training in run
            always_comb begin
                we      = 1'b0;
                wr_addr = tr_addr;
                wr_data = trained;
                if (!rst) begin
                    if (in_init) begin
                        we      = 1'b1;
                        wr_addr = init_addr_q;
                        wr_data = '0;
                    end else if (train_we) begin
                        we      = 1'b1;
                    end
                end
            end

            // Block RAM: write port plus registered read-first read port
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wr_addr] <= wr_data;
                end
                if (accept) begin
                    ram_rd_q <= mem[rd_addr];
                end
            end

`ifdef PERCEPTRON_WEIGHT_BYPASS_EN
            logic                byp_hit_q,  byp_hit_d;
            logic [WEIGHT_W-1:0] byp_data_q, byp_data_d;

            // Detect a same-edge read/train collision on this bank
            always_comb begin
                byp_hit_d  = train_we && (tr_addr == rd_addr);
                byp_data_d = trained;
            end

            // Remember the colliding write so the read output can replace it
            always_ff @(posedge clk) begin
                if (rst) begin
                    byp_hit_q  <= 1'b0;
                    byp_data_q <= '0;
                end else if (accept) begin
                    byp_hit_q  <= byp_hit_d;
                    byp_data_q <= byp_data_d;
                end
            end

            assign rd_w = byp_hit_q ? byp_data_q : ram_rd_q;
`else
            assign rd_w = ram_rd_q;
`endif

            assign rd_w_all[gi*WEIGHT_W +: WEIGHT_W] = rd_w;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pred_ready   = pred_ready;
    assign bus.pred_valid   = pred_valid_q;
    assign bus.pred_weights = pred_valid_q ? rd_w_all : '0;
    assign bus.res_error    = res_error_q;
    assign bus.init_busy    = in_init;
    assign bus.inflight_cnt = cnt_q;

endmodule

// File: tb/tb_perceptron_weight_bank.sv
// tb_perceptron_weight_bank
// Directed tests for perceptron_weight_bank with hand-computed expectations.
// Honours PERCEPTRON_WEIGHT_BYPASS_EN for the collision expectation.
module tb_perceptron_weight_bank;
    localparam int NW    = 16;
    localparam int WW    = 3;
    localparam int IW    = 10;
    localparam int PD    = 4;
    localparam int DEPTH = 1 << IW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    perceptron_weight_bank_if #(
        .NUM_WEIGHTS(NW), .WEIGHT_W(WW), .INDEX_W(IW), .PIPE_DEPTH(PD)
    ) bus ();

    perceptron_weight_bank #(
        .NUM_WEIGHTS(NW), .WEIGHT_W(WW), .INDEX_W(IW), .PIPE_DEPTH(PD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW*WW-1:0] rep_w(input int w);
        logic [NW*WW-1:0] v;
        logic [WW-1:0]    ws;
        ws = WW'(w);
        for (int k = 0; k < NW; k++) v[k*WW +: WW] = ws;
        return v;
    endfunction

    function automatic logic [NW*IW-1:0] rep_i(input int i);
        logic [NW*IW-1:0] v;
        logic [IW-1:0]    is;
        is = IW'(i);
        for (int k = 0; k < NW; k++) v[k*IW +: IW] = is;
        return v;
    endfunction

    task automatic predict(input logic [NW*IW-1:0] idx);
        bus.pred_en    = 1'b1;
        bus.pred_index = idx;
        tick();
        bus.pred_en    = 1'b0;
        $display("[%0t] predict idx0=%0h -> valid=%b w=%h cnt=%0d",
                 $time, idx[IW-1:0], bus.pred_valid, bus.pred_weights, bus.inflight_cnt);
    endtask

    task automatic resolve(input logic train, input logic [NW-1:0] dir);
        bus.res_en    = 1'b1;
        bus.res_train = train;
        bus.res_dir   = dir;
        tick();
        bus.res_en    = 1'b0;
        bus.res_train = 1'b0;
        $display("[%0t] resolve train=%b dir=%h -> cnt=%0d err=%b",
                 $time, train, dir, bus.inflight_cnt, bus.res_error);
    endtask

    // Wait out a zeroing sweep, checking that nothing is accepted meanwhile
    task automatic wait_sweep(input string tag);
        int cycles;
        bit ready_seen;
        bit err_seen;
        bit valid_seen;
        cycles = 0; ready_seen = 0; err_seen = 0; valid_seen = 0;
        bus.pred_en    = 1'b1;
        bus.pred_index = rep_i(5);
        bus.res_en     = 1'b1;
        bus.res_train  = 1'b1;
        bus.res_dir    = '1;
        while (bus.init_busy === 1'b1 && cycles < 3000) begin
            if (bus.pred_ready !== 1'b0) ready_seen = 1;
            if (bus.res_error  !== 1'b0) err_seen   = 1;
            if (bus.pred_valid !== 1'b0) valid_seen = 1;
            tick();
            cycles++;
        end
        bus.pred_en   = 1'b0;
        bus.res_en    = 1'b0;
        bus.res_train = 1'b0;
        $display("[%0t] %s sweep done after %0d cycles", $time, tag, cycles);
        checks++;
        if (cycles !== DEPTH) begin
            errors++;
            $display("FAIL %s_sweep_len: got %0d cycles expected %0d", tag, cycles, DEPTH);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL %s_ready_in_init: got pred_ready=1 expected 0", tag);
        end
        checks++;
        if (err_seen || valid_seen) begin
            errors++;
            $display("FAIL %s_activity_in_init: got err=%b valid=%b expected 0 0", tag, err_seen, valid_seen);
        end
        checks++;
        if (bus.inflight_cnt !== 3'd0 || bus.pred_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_sweep: got cnt=%0d ready=%b expected 0 1", tag, bus.inflight_cnt, bus.pred_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.init_busy !== 1'b1 || bus.pred_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_ready: got busy=%b ready=%b expected 1 0", bus.init_busy, bus.pred_ready);
        end
        checks++;
        if (bus.pred_valid !== 1'b0 || bus.pred_weights !== '0) begin
            errors++;
            $display("FAIL reset_pred: got valid=%b w=%h expected 0 0", bus.pred_valid, bus.pred_weights);
        end
        checks++;
        if (bus.inflight_cnt !== 3'd0 || bus.res_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_err: got cnt=%0d err=%b expected 0 0", bus.inflight_cnt, bus.res_error);
        end
        rst = 1'b0;
        wait_sweep("init");
    endtask

    task automatic test_first_predict();
        predict(rep_i(10'h155));
        checks++;
        if (bus.pred_valid !== 1'b1 || bus.pred_weights !== rep_w(0)) begin
            errors++;
            $display("FAIL first_predict: got valid=%b w=%h expected 1 %h", bus.pred_valid, bus.pred_weights, rep_w(0));
        end
        tick();
        checks++;
        if (bus.pred_valid !== 1'b0 || bus.pred_weights !== '0) begin
            errors++;
            $display("FAIL idle_output: got valid=%b w=%h expected 0 0", bus.pred_valid, bus.pred_weights);
        end
        resolve(1'b0, '0);
        checks++;
        if (bus.inflight_cnt !== 3'd0) begin
            errors++;
            $display("FAIL first_pop_cnt: got %0d expected 0", bus.inflight_cnt);
        end
    endtask

    task automatic test_train_saturate();
        int up_exp [4] = '{0, 1, 2, 3};
        int dn_exp [9] = '{3, 2, 1, 0, -1, -2, -3, -4, -4};
        logic [NW*WW-1:0] mix_exp;
        logic [NW-1:0]    mix_dir;
        for (int i = 0; i < 4; i++) begin
            predict(rep_i(5));
            checks++;
            if (bus.pred_weights !== rep_w(up_exp[i])) begin
                errors++;
                $display("FAIL train_up_%0d: got %h expected %h", i, bus.pred_weights, rep_w(up_exp[i]));
            end
            resolve(1'b1, '1);
        end
        for (int i = 0; i < 9; i++) begin
            predict(rep_i(5));
            checks++;
            if (bus.pred_weights !== rep_w(dn_exp[i])) begin
                errors++;
                $display("FAIL train_down_%0d: got %h expected %h", i, bus.pred_weights, rep_w(dn_exp[i]));
            end
            resolve(i < 8, '0);
        end
        // per-bank directions: +1 where dir bit set, -1 elsewhere
        mix_dir = 16'hA5A5;
        for (int k = 0; k < NW; k++) mix_exp[k*WW +: WW] = mix_dir[k] ? 3'b001 : 3'b111;
        predict(rep_i(9));
        resolve(1'b1, mix_dir);
        predict(rep_i(9));
        checks++;
        if (bus.pred_weights !== mix_exp) begin
            errors++;
            $display("FAIL train_mixed_dir: got %h expected %h", bus.pred_weights, mix_exp);
        end
        resolve(1'b0, '0);
    endtask

    task automatic test_fifo_full();
        int ord_exp [4] = '{1, -1, 0, 1};
        bus.pred_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pred_index = rep_i(20 + i);
            tick();
            $display("[%0t] predict idx0=%0h -> valid=%b cnt=%0d", $time, 20 + i, bus.pred_valid, bus.inflight_cnt);
        end
        bus.pred_index = rep_i(24);
        checks++;
        if (bus.inflight_cnt !== 3'd4 || bus.pred_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got cnt=%0d ready=%b expected 4 0", bus.inflight_cnt, bus.pred_ready);
        end
        tick();
        bus.pred_en = 1'b0;
        $display("[%0t] predict idx0=18 (full) -> valid=%b cnt=%0d", $time, bus.pred_valid, bus.inflight_cnt);
        checks++;
        if (bus.pred_valid !== 1'b0 || bus.inflight_cnt !== 3'd4) begin
            errors++;
            $display("FAIL full_reject: got valid=%b cnt=%0d expected 0 4", bus.pred_valid, bus.inflight_cnt);
        end
        resolve(1'b1, '1);
        checks++;
        if (bus.inflight_cnt !== 3'd3 || bus.pred_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop: got cnt=%0d ready=%b expected 3 1", bus.inflight_cnt, bus.pred_ready);
        end
        resolve(1'b1, '0);
        resolve(1'b0, '0);
        resolve(1'b1, '1);
        // oldest-first order: idx20 +1, idx21 -1, idx22 untouched, idx23 +1
        for (int i = 0; i < 4; i++) begin
            predict(rep_i(20 + i));
            checks++;
            if (bus.pred_weights !== rep_w(ord_exp[i])) begin
                errors++;
                $display("FAIL fifo_order_%0d: got %h expected %h", i, bus.pred_weights, rep_w(ord_exp[i]));
            end
            resolve(1'b0, '0);
        end
    endtask

    task automatic test_back_to_back();
        predict(rep_i(30));
        bus.pred_en    = 1'b1;
        bus.pred_index = rep_i(31);
        bus.res_en     = 1'b1;
        bus.res_train  = 1'b1;
        bus.res_dir    = '1;
        tick();
        bus.pred_en    = 1'b0;
        bus.res_en     = 1'b0;
        bus.res_train  = 1'b0;
        $display("[%0t] predict+resolve -> valid=%b cnt=%0d", $time, bus.pred_valid, bus.inflight_cnt);
        checks++;
        if (bus.inflight_cnt !== 3'd1 || bus.pred_valid !== 1'b1 || bus.pred_weights !== rep_w(0)) begin
            errors++;
            $display("FAIL b2b_push_pop: got cnt=%0d valid=%b w=%h expected 1 1 0", bus.inflight_cnt, bus.pred_valid, bus.pred_weights);
        end
        resolve(1'b1, '1);
        predict(rep_i(30));
        checks++;
        if (bus.pred_weights !== rep_w(1)) begin
            errors++;
            $display("FAIL b2b_idx30: got %h expected %h", bus.pred_weights, rep_w(1));
        end
        resolve(1'b0, '0);
        predict(rep_i(31));
        checks++;
        if (bus.pred_weights !== rep_w(1)) begin
            errors++;
            $display("FAIL b2b_idx31: got %h expected %h", bus.pred_weights, rep_w(1));
        end
        resolve(1'b0, '0);
    endtask

    task automatic test_empty_resolve();
        resolve(1'b1, '1);
        checks++;
        if (bus.res_error !== 1'b1 || bus.inflight_cnt !== 3'd0) begin
            errors++;
            $display("FAIL empty_err_pulse: got err=%b cnt=%0d expected 1 0", bus.res_error, bus.inflight_cnt);
        end
        tick();
        checks++;
        if (bus.res_error !== 1'b0) begin
            errors++;
            $display("FAIL empty_err_width: got err=%b expected 0", bus.res_error);
        end
        predict(rep_i(5));
        checks++;
        if (bus.pred_weights !== rep_w(-4)) begin
            errors++;
            $display("FAIL empty_no_write: got %h expected %h", bus.pred_weights, rep_w(-4));
        end
        resolve(1'b0, '0);
    endtask

    task automatic test_collision();
        logic [NW*IW-1:0] idx78;
        logic [NW*WW-1:0] exp_w;
        int b0_first;
        int b0_second;
`ifdef PERCEPTRON_WEIGHT_BYPASS_EN
        b0_first  = 3;
        b0_second = 2;
`else
        b0_first  = 2;
        b0_second = 1;
`endif
        idx78 = rep_i(8);
        idx78[IW-1:0] = IW'(7);
        // bring idx 7 to +2 in every bank
        predict(rep_i(7));
        resolve(1'b1, '1);
        predict(rep_i(7));
        resolve(1'b1, '1);
        predict(rep_i(7));
        checks++;
        if (bus.pred_weights !== rep_w(2)) begin
            errors++;
            $display("FAIL coll_setup: got %h expected %h", bus.pred_weights, rep_w(2));
        end
        // train idx 7 to +3 while bank 0 reads idx 7 (others read idx 8)
        bus.pred_en    = 1'b1;
        bus.pred_index = idx78;
        bus.res_en     = 1'b1;
        bus.res_train  = 1'b1;
        bus.res_dir    = '1;
        tick();
        bus.pred_en    = 1'b0;
        bus.res_en     = 1'b0;
        bus.res_train  = 1'b0;
        $display("[%0t] collision predict+train -> w=%h cnt=%0d", $time, bus.pred_weights, bus.inflight_cnt);
        exp_w = rep_w(0);
        exp_w[WW-1:0] = WW'(b0_first);
        checks++;
        if (bus.pred_weights !== exp_w || bus.inflight_cnt !== 3'd1) begin
            errors++;
            $display("FAIL coll_read: got w=%h cnt=%0d expected %h 1", bus.pred_weights, bus.inflight_cnt, exp_w);
        end
        // train the collided snapshot down: bank0 idx7 gets first-1, idx8 gets -1
        resolve(1'b1, '0);
        predict(idx78);
        exp_w = rep_w(-1);
        exp_w[WW-1:0] = WW'(b0_second);
        checks++;
        if (bus.pred_weights !== exp_w) begin
            errors++;
            $display("FAIL coll_snapshot: got %h expected %h", bus.pred_weights, exp_w);
        end
        resolve(1'b0, '0);
        predict(rep_i(7));
        exp_w = rep_w(3);
        exp_w[WW-1:0] = WW'(b0_second);
        checks++;
        if (bus.pred_weights !== exp_w) begin
            errors++;
            $display("FAIL coll_other_banks: got %h expected %h", bus.pred_weights, exp_w);
        end
        resolve(1'b0, '0);
    endtask

    task automatic test_reset_midrun();
        int idx_list [5] = '{5, 7, 9, 20, 31};
        predict(rep_i(5));
        predict(rep_i(7));
        predict(rep_i(9));
        checks++;
        if (bus.inflight_cnt !== 3'd3) begin
            errors++;
            $display("FAIL midrun_pre_cnt: got %0d expected 3", bus.inflight_cnt);
        end
        rst = 1'b1;
        tick();
        $display("[%0t] reset mid-run -> busy=%b cnt=%0d", $time, bus.init_busy, bus.inflight_cnt);
        checks++;
        if (bus.inflight_cnt !== 3'd0 || bus.init_busy !== 1'b1 || bus.pred_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got cnt=%0d busy=%b valid=%b expected 0 1 0",
                     bus.inflight_cnt, bus.init_busy, bus.pred_valid);
        end
        rst = 1'b0;
        wait_sweep("rerun");
        for (int i = 0; i < 5; i++) begin
            predict(rep_i(idx_list[i]));
            checks++;
            if (bus.pred_weights !== rep_w(0)) begin
                errors++;
                $display("FAIL midrun_zero_idx%0d: got %h expected 0", idx_list[i], bus.pred_weights);
            end
            resolve(1'b0, '0);
        end
    endtask

    // Absolute time bound in case the design never leaves a wait
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.pred_en    = 1'b0;
        bus.pred_index = '0;
        bus.res_en     = 1'b0;
        bus.res_train  = 1'b0;
        bus.res_dir    = '0;
        test_reset();
        test_first_predict();
        test_train_saturate();
        test_fifo_full();
        test_back_to_back();
        test_empty_resolve();
        test_collision();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
